// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared arbiter state encoding and default burst limit.
package uio_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_e;
  localparam int MAX_BURST_DEF = 16;
endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// rr_pick: round-robin selector; lowest offset from ptr among set requests wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            valid
);
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) win = NREQ'(1) << ((int'(ptr) + k) % NREQ);
  end
  assign valid = |req;
endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin uio bus arbiter with one-cycle turnaround between owners.
// Define UIO_ARB_TIMEOUT_EN to force hand-over after MAX_BURST grant cycles when others wait.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_out,
  input  logic [NREQ*8-1:0] req_oe,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("uio_bus_arbiter: parameter out of range");
  end
  arb_state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, win;
  logic [PW-1:0] ptr_q, ptr_d, widx;
  logic valid, sel, own, expire;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(req), .ptr(ptr_q), .win(win), .valid(valid));
  always_comb begin
    widx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) widx = PW'(i);
  end
  assign sel = ena && valid && state_q != GRANT;
  assign own = |(req & gnt_q);
`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] burst_q, burst_d;
  assign expire = burst_q >= 8'(MAX_BURST - 1) && |(req & ~gnt_q);
  assign burst_d = sel ? '0 : (state_q == GRANT && !(&burst_q)) ? burst_q + 8'd1 : burst_q;
  always_ff @(posedge clk) burst_q <= rst ? '0 : burst_d;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (sel) begin
      state_d = GRANT;
      gnt_d = win;
      ptr_d = widx == PW'(NREQ - 1) ? '0 : widx + 1'b1;
    end else if (state_q == GRANT && (!own || expire)) begin
      state_d = TURN;
      gnt_d = '0;
    end else if (state_q == TURN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end
  // gnt_q is one-hot or zero, so an OR-reduction acts as the data mux
  always_comb begin
    uio_out = '0;
    uio_oe = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) begin
        uio_out = uio_out | req_out[8*i +: 8];
        uio_oe = uio_oe | req_oe[8*i +: 8];
      end
  end
  assign gnt = gnt_q;
  assign busy = state_q != IDLE;
endmodule
